// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Holds the FSM state encoding, owner codes and default bus widths.
package ram_arb_pkg;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 8;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LD  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the CPU port, loader port and RAM macro port around the arbiter.
// slave = arbiter side, master = requesters plus RAM model side.
interface ram_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      output ld_gnt, ld_rvalid, ld_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata,
      output ld_req, ld_we, ld_addr, ld_wdata,
      input  ld_gnt, ld_rvalid, ld_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata,
      input  busy
   );

endinterface

// File: rtl/ram_arb_pick.sv
// Winner select for the RAM arbiter: CPU by default, loader when the CPU is idle
// or after STARVE_LIM consecutive CPU grants taken while the loader waited.
module ram_arb_pick
   import ram_arb_pkg::*;
#(
   parameter int STARVE_LIM = 3
) (
   input  logic clk,
   input  logic res,
   input  logic i_cpu_req,
   input  logic i_ld_req,
   input  logic i_idle,
   input  logic i_gnt,
   output logic o_owner
);

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   logic [3:0] r_starve_cnt;
   logic       w_ld_wins;

   assign w_ld_wins = i_ld_req && (!i_cpu_req || (r_starve_cnt >= LIM));
   assign o_owner   = w_ld_wins ? OWN_LD : OWN_CPU;

   // A loader win or an idle cycle without a pending loader request ends the starvation run.
   always_ff @(posedge clk) begin
      if (!res) begin
         r_starve_cnt <= 4'd0;
      end else if (i_gnt && w_ld_wins) begin
         r_starve_cnt <= 4'd0;
      end else if (i_idle && !i_ld_req) begin
         r_starve_cnt <= 4'd0;
      end else if (i_gnt && i_ld_req && (r_starve_cnt != 4'hF)) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises CPU and loader accesses onto the single-port program/data RAM.
// IDLE arbitrates, ISSUE strobes the RAM, RESP returns read data to the owner.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_LIM = 3
) (
   input  logic          clk,
   input  logic          res,
   ram_arbiter_if.slave  bus
);

   state_t            r_state;
   logic              r_owner;
   logic              r_cpu_gnt;
   logic              r_ld_gnt;
   logic              r_cpu_rvalid;
   logic              r_ld_rvalid;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_ld_rdata;
   logic              r_ram_en;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_busy;

   logic w_idle;
   logic w_gnt_evt;
   logic w_owner;

   assign w_idle    = (r_state == IDLE);
   assign w_gnt_evt = w_idle && (bus.cpu_req || bus.ld_req);

   ram_arb_pick #(
      .STARVE_LIM (STARVE_LIM)
   ) u_pick (
      .clk       (clk),
      .res       (res),
      .i_cpu_req (bus.cpu_req),
      .i_ld_req  (bus.ld_req),
      .i_idle    (w_idle),
      .i_gnt     (w_gnt_evt),
      .o_owner   (w_owner)
   );

   // The ram_* registers double as the request latches; ram_we is kept until ISSUE decides write vs read.
   always_ff @(posedge clk) begin
      if (!res) begin
         r_state      <= IDLE;
         r_owner      <= OWN_CPU;
         r_cpu_gnt    <= 1'b0;
         r_ld_gnt     <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_ld_rvalid  <= 1'b0;
         r_cpu_rdata  <= '0;
         r_ld_rdata   <= '0;
         r_ram_en     <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_cpu_gnt    <= 1'b0;
         r_ld_gnt     <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_ld_rvalid  <= 1'b0;
         r_ram_en     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_gnt_evt) begin
                  r_owner     <= w_owner;
                  r_ram_en    <= 1'b1;
                  r_ram_we    <= (w_owner == OWN_LD) ? bus.ld_we    : bus.cpu_we;
                  r_ram_addr  <= (w_owner == OWN_LD) ? bus.ld_addr  : bus.cpu_addr;
                  r_ram_wdata <= (w_owner == OWN_LD) ? bus.ld_wdata : bus.cpu_wdata;
                  r_cpu_gnt   <= (w_owner == OWN_CPU);
                  r_ld_gnt    <= (w_owner == OWN_LD);
                  r_busy      <= 1'b1;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               r_ram_we <= 1'b0;
               if (r_ram_we) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_state <= RESP;
               end
            end
            RESP: begin
               if (r_owner == OWN_LD) begin
                  r_ld_rdata  <= bus.ram_rdata;
                  r_ld_rvalid <= 1'b1;
               end else begin
                  r_cpu_rdata  <= bus.ram_rdata;
                  r_cpu_rvalid <= 1'b1;
               end
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_gnt    = r_cpu_gnt;
   assign bus.ld_gnt     = r_ld_gnt;
   assign bus.cpu_rvalid = r_cpu_rvalid;
   assign bus.ld_rvalid  = r_ld_rvalid;
   assign bus.cpu_rdata  = r_cpu_rdata;
   assign bus.ld_rdata   = r_ld_rdata;
   assign bus.ram_en     = r_ram_en;
   assign bus.ram_we     = r_ram_we;
   assign bus.ram_addr   = r_ram_addr;
   assign bus.ram_wdata  = r_ram_wdata;
   assign bus.busy       = r_busy;

endmodule
